// File: rtl/ntt_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the NTT host front end.
package ntt_pkg;

    localparam logic [4:0] OP_NONE    = 5'b00000;
    localparam logic [4:0] OP_LD_PRM  = 5'b00001;
    localparam logic [4:0] OP_LD_W    = 5'b00010;
    localparam logic [4:0] OP_LD_DATA = 5'b00011;
    localparam logic [4:0] OP_NTT     = 5'b00100;
    localparam logic [4:0] OP_INTT    = 5'b00111;
    localparam logic [4:0] OP_PWM     = 5'b01010;

    localparam int PRM_WORDS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_PRM  = 2'd1,
        ST_LD_W    = 2'd2,
        ST_LD_DATA = 2'd3
    } ntt_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int width_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ntt_bank_addr_gen.sv
// Maps a linear word index onto polynomial / PE bank / in-bank address for a given ring depth.
module ntt_bank_addr_gen #(
    parameter int KW = 13,
    parameter int PW = 1,
    parameter int BW = 4,
    parameter int AW = 6
) (
    input  logic [KW-1:0] k,
    input  logic [3:0]    ring_depth,
    output logic [PW-1:0] d_poly,
    output logic [BW-1:0] d_bank,
    output logic [AW-1:0] d_addr
);

    logic [KW-1:0] j;

    always_comb begin
        j      = k & ~({KW{1'b1}} << ring_depth);
        d_poly = PW'(k >> ring_depth);
        d_bank = BW'(j);
        d_addr = AW'(j >> BW);
    end

endmodule

// File: rtl/ntt_host_ctrl.sv
// Host command decoder and streamed-load sequencer for the NTT core memories.
//   state      | meaning
//   ST_IDLE    | waiting for a command; START_* pulses issued from here
//   ST_LD_PRM  | consuming the 3 parameter words
//   ST_LD_W    | consuming W_COUNT twiddle words
//   ST_LD_DATA | consuming NUM_POLY * 2^ring_depth data words
module ntt_host_ctrl
    import ntt_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int PE_DEPTH       = 3,
    parameter int MAX_RING_DEPTH = 10,
    parameter int NUM_POLY       = 2,
    parameter int W_COUNT        = 2552
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [4:0]                               OP_CODE,
    input  logic                                     din_valid,
    input  logic [DATA_W-1:0]                        din0,
    input  logic [3:0]                               ring_depth,
    output logic                                     prm_we,
    output logic [1:0]                               prm_sel,
    output logic                                     w_we,
    output logic [clog2(W_COUNT)-1:0]                w_addr,
    output logic                                     d_we,
    output logic [PE_DEPTH:0]                        d_bank,
    output logic [width_min1(clog2(NUM_POLY))-1:0]   d_poly,
    output logic [MAX_RING_DEPTH-PE_DEPTH-2:0]       d_addr,
    output logic [DATA_W-1:0]                        wdata,
    output logic                                     start_ntt,
    output logic                                     start_intt,
    output logic                                     start_pwm,
    output logic                                     load_done,
    output logic                                     busy,
    output logic                                     err
);

    localparam int WAW  = clog2(W_COUNT);
    localparam int PW   = width_min1(clog2(NUM_POLY));
    localparam int BW   = PE_DEPTH + 1;
    localparam int AW   = MAX_RING_DEPTH - PE_DEPTH - 1;
    localparam int MAXW = max_int(max_int(PRM_WORDS, W_COUNT), NUM_POLY << MAX_RING_DEPTH);
    localparam int KW   = clog2(MAXW) + 1;

    localparam logic [3:0] RD_MIN = 4'(BW);
    localparam logic [3:0] RD_MAX = 4'(MAX_RING_DEPTH);

    ntt_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_last_q, k_last_d;
    logic [3:0] rd_q, rd_d;

    logic              prm_we_q, prm_we_d, w_we_q, w_we_d, d_we_q, d_we_d;
    logic [1:0]        prm_sel_q, prm_sel_d;
    logic [WAW-1:0]    w_addr_q, w_addr_d;
    logic [BW-1:0]     d_bank_q, d_bank_d;
    logic [PW-1:0]     d_poly_q, d_poly_d;
    logic [AW-1:0]     d_addr_q, d_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_ntt_q, start_ntt_d, start_intt_q, start_intt_d;
    logic              start_pwm_q, start_pwm_d, load_done_q, load_done_d;
    logic              busy_q, busy_d, err_q, err_d;

    logic [PW-1:0] gen_poly;
    logic [BW-1:0] gen_bank;
    logic [AW-1:0] gen_addr;
    logic          rd_ok;

    ntt_bank_addr_gen #(.KW(KW), .PW(PW), .BW(BW), .AW(AW)) u_addr_gen (
        .k          (k_q),
        .ring_depth (rd_q),
        .d_poly     (gen_poly),
        .d_bank     (gen_bank),
        .d_addr     (gen_addr)
    );

    assign rd_ok = (ring_depth >= RD_MIN) && (ring_depth <= RD_MAX);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        k_last_d     = k_last_q;
        rd_d         = rd_q;
        prm_we_d     = 1'b0;
        w_we_d       = 1'b0;
        d_we_d       = 1'b0;
        prm_sel_d    = prm_sel_q;
        w_addr_d     = w_addr_q;
        d_bank_d     = d_bank_q;
        d_poly_d     = d_poly_q;
        d_addr_d     = d_addr_q;
        wdata_d      = wdata_q;
        start_ntt_d  = 1'b0;
        start_intt_d = 1'b0;
        start_pwm_d  = 1'b0;
        load_done_d  = 1'b0;
        err_d        = 1'b0;

        if (state_q == ST_IDLE) begin
            case (OP_CODE)
                OP_NONE: ;
                OP_LD_PRM: begin
                    state_d  = ST_LD_PRM;
                    k_d      = '0;
                    k_last_d = KW'(PRM_WORDS - 1);
                end
                OP_LD_W: begin
                    state_d  = ST_LD_W;
                    k_d      = '0;
                    k_last_d = KW'(W_COUNT - 1);
                end
                OP_LD_DATA: begin
                    if (rd_ok) begin
                        state_d  = ST_LD_DATA;
                        k_d      = '0;
                        k_last_d = (KW'(NUM_POLY) << ring_depth) - KW'(1);
                        rd_d     = ring_depth;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_NTT:  if (rd_ok) start_ntt_d  = 1'b1; else err_d = 1'b1;
                OP_INTT: if (rd_ok) start_intt_d = 1'b1; else err_d = 1'b1;
                OP_PWM:  if (rd_ok) start_pwm_d  = 1'b1; else err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end else begin
            // Commands during a load are refused but the stream keeps flowing.
            if (OP_CODE != OP_NONE) err_d = 1'b1;
            if (din_valid) begin
                wdata_d = din0;
                k_d     = k_q + KW'(1);
                case (state_q)
                    ST_LD_PRM: begin
                        prm_we_d  = 1'b1;
                        prm_sel_d = k_q[1:0];
                    end
                    ST_LD_W: begin
                        w_we_d   = 1'b1;
                        w_addr_d = k_q[WAW-1:0];
                    end
                    ST_LD_DATA: begin
                        d_we_d   = 1'b1;
                        d_poly_d = gen_poly;
                        d_bank_d = gen_bank;
                        d_addr_d = gen_addr;
                    end
                    default: ;
                endcase
                if (k_q == k_last_q) begin
                    state_d     = ST_IDLE;
                    k_d         = '0;
                    load_done_d = 1'b1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            k_last_q     <= '0;
            rd_q         <= '0;
            prm_we_q     <= 1'b0;
            w_we_q       <= 1'b0;
            d_we_q       <= 1'b0;
            prm_sel_q    <= '0;
            w_addr_q     <= '0;
            d_bank_q     <= '0;
            d_poly_q     <= '0;
            d_addr_q     <= '0;
            wdata_q      <= '0;
            start_ntt_q  <= 1'b0;
            start_intt_q <= 1'b0;
            start_pwm_q  <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            k_last_q     <= k_last_d;
            rd_q         <= rd_d;
            prm_we_q     <= prm_we_d;
            w_we_q       <= w_we_d;
            d_we_q       <= d_we_d;
            prm_sel_q    <= prm_sel_d;
            w_addr_q     <= w_addr_d;
            d_bank_q     <= d_bank_d;
            d_poly_q     <= d_poly_d;
            d_addr_q     <= d_addr_d;
            wdata_q      <= wdata_d;
            start_ntt_q  <= start_ntt_d;
            start_intt_q <= start_intt_d;
            start_pwm_q  <= start_pwm_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign prm_we     = prm_we_q;
    assign prm_sel    = prm_sel_q;
    assign w_we       = w_we_q;
    assign w_addr     = w_addr_q;
    assign d_we       = d_we_q;
    assign d_bank     = d_bank_q;
    assign d_poly     = d_poly_q;
    assign d_addr     = d_addr_q;
    assign wdata      = wdata_q;
    assign start_ntt  = start_ntt_q;
    assign start_intt = start_intt_q;
    assign start_pwm  = start_pwm_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ntt_host_ctrl.sv
// Bench for ntt_host_ctrl: command table plus scoreboard of expected memory writes.
module tb_ntt_host_ctrl;

    localparam int W_COUNT = 2552;
    localparam int NB      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  OP_CODE;
    logic        din_valid;
    logic [31:0] din0;
    logic [3:0]  ring_depth;
    logic        prm_we, w_we, d_we;
    logic [1:0]  prm_sel;
    logic [11:0] w_addr;
    logic [3:0]  d_bank;
    logic [0:0]  d_poly;
    logic [5:0]  d_addr;
    logic [31:0] wdata;
    logic        start_ntt, start_intt, start_pwm, load_done, busy, err;

    ntt_host_ctrl dut (
        .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .din_valid(din_valid),
        .din0(din0), .ring_depth(ring_depth), .prm_we(prm_we), .prm_sel(prm_sel),
        .w_we(w_we), .w_addr(w_addr), .d_we(d_we), .d_bank(d_bank),
        .d_poly(d_poly), .d_addr(d_addr), .wdata(wdata), .start_ntt(start_ntt),
        .start_intt(start_intt), .start_pwm(start_pwm), .load_done(load_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 param, 1 twiddle, 2 data
        int          k;
        int          poly;
        int          bank;
        int          addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    typedef struct {
        logic [4:0] op;
        logic [3:0] rd;
        int         nw;
        bit         exp_err;
        int         start;   // 0 none, 1 ntt, 2 intt, 3 pwm
    } cmd_t;

    typedef struct {
        int rd;
        int k;
        int poly;
        int bank;
        int addr;
    } spot_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cap_poly[4096];
    int   cap_bank[4096];
    int   cap_addr[4096];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prm_we || w_we || d_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {61'd0, prm_we, w_we, d_we}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("strobes", {61'd0, prm_we, w_we, d_we},
                      {61'd0, e.kind == 0, e.kind == 1, e.kind == 2});
                check("wdata", wdata, e.data);
                check("load_done", load_done, e.last);
                check("busy_on_write", busy, !e.last);
                if (e.kind == 0) begin
                    check("prm_sel", prm_sel, e.k);
                end else if (e.kind == 1) begin
                    check("w_addr", w_addr, e.k);
                end else begin
                    check("d_poly", d_poly, e.poly);
                    check("d_bank", d_bank, e.bank);
                    check("d_addr", d_addr, e.addr);
                    cap_poly[e.k] = d_poly;
                    cap_bank[e.k] = d_bank;
                    cap_addr[e.k] = d_addr;
                end
            end
        end else begin
            check("done_without_write", load_done, 0);
        end
    end

    task automatic push_word(input int kind, input int k, input int rd, input logic [31:0] data,
                             input bit last);
        exp_t e;
        int   j;
        e.kind = kind;
        e.k    = k;
        e.data = data;
        e.last = last;
        e.poly = 0;
        e.bank = 0;
        e.addr = 0;
        if (kind == 2) begin
            j      = k % (1 << rd);
            e.poly = k / (1 << rd);
            e.bank = j % NB;
            e.addr = j / NB;
        end
        sb.push_back(e);
    endtask

    // Streams words with random gaps; stop_at cuts the load short, inject_at overlaps a START_NTT.
    task automatic feed(input int kind, input int nw, input int rd, input int stop_at,
                        input int inject_at);
        logic [31:0] v;
        for (int k = 0; k < nw; k++) begin
            if (k == stop_at) break;
            if ($urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
                tick();
            end
            v          = $urandom;
            din_valid  = 1'b1;
            din0       = v;
            ring_depth = 4'($urandom);
            if (k == inject_at) begin
                OP_CODE    = 5'b00100;
                ring_depth = 4'd10;
            end
            push_word(kind, k, rd, v, k == nw - 1);
            tick();
            if (k == inject_at) begin
                OP_CODE = 5'b00000;
                check("busy_reject_err", err, 1);
                check("busy_reject_no_start", start_ntt, 0);
            end
        end
    endtask

    task automatic run_cmd(input cmd_t c);
        OP_CODE    = c.op;
        ring_depth = c.rd;
        din_valid  = 1'b1;
        din0       = 32'hBAD0_0000 | 32'(c.op);
        tick();
        OP_CODE   = 5'b00000;
        din_valid = 1'b0;
        check("accept_err", err, c.exp_err);
        check("accept_start_ntt", start_ntt, c.start == 1);
        check("accept_start_intt", start_intt, c.start == 2);
        check("accept_start_pwm", start_pwm, c.start == 3);
        check("accept_busy", busy, c.nw > 0);
        if (c.nw > 0) begin
            feed(int'(c.op) - 1, c.nw, int'(c.rd), -1, -1);
            din_valid = 1'b0;
            tick();
            tick();
            check("load_drained", sb.size(), 0);
            check("busy_after_load", busy, 0);
        end else begin
            tick();
            check("pulses_cleared", {60'd0, err, start_ntt, start_intt, start_pwm}, 64'd0);
            check("still_idle", busy, 0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {prm_we, prm_sel, w_we, w_addr, d_we, d_bank, d_poly, d_addr,
                     start_ntt, start_intt, start_pwm, load_done, busy, err}, 64'd0);
        check({name, "_wdata"}, wdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t  cmds[11];
        spot_t spots[8];
        cmd_t  prm_cmd;

        cmds[0]  = '{op: 5'b00011, rd: 4'd10, nw: 2048, exp_err: 1'b0, start: 0};
        cmds[1]  = '{op: 5'b00011, rd: 4'd4,  nw: 32,   exp_err: 1'b0, start: 0};
        cmds[2]  = '{op: 5'b00011, rd: 4'd3,  nw: 0,    exp_err: 1'b1, start: 0};
        cmds[3]  = '{op: 5'b00011, rd: 4'd11, nw: 0,    exp_err: 1'b1, start: 0};
        cmds[4]  = '{op: 5'b00100, rd: 4'd10, nw: 0,    exp_err: 1'b0, start: 1};
        cmds[5]  = '{op: 5'b00111, rd: 4'd5,  nw: 0,    exp_err: 1'b0, start: 2};
        cmds[6]  = '{op: 5'b01010, rd: 4'd4,  nw: 0,    exp_err: 1'b0, start: 3};
        cmds[7]  = '{op: 5'b01010, rd: 4'd3,  nw: 0,    exp_err: 1'b1, start: 0};
        cmds[8]  = '{op: 5'b11111, rd: 4'd10, nw: 0,    exp_err: 1'b1, start: 0};
        cmds[9]  = '{op: 5'b00101, rd: 4'd10, nw: 0,    exp_err: 1'b1, start: 0};
        cmds[10] = '{op: 5'b00001, rd: 4'd0,  nw: 3,    exp_err: 1'b0, start: 0};
        prm_cmd  = cmds[10];

        spots[0] = '{rd: 10, k: 0,    poly: 0, bank: 0,  addr: 0};
        spots[1] = '{rd: 10, k: 17,   poly: 0, bank: 1,  addr: 1};
        spots[2] = '{rd: 10, k: 1024, poly: 1, bank: 0,  addr: 0};
        spots[3] = '{rd: 10, k: 2047, poly: 1, bank: 15, addr: 63};
        spots[4] = '{rd: 4,  k: 0,    poly: 0, bank: 0,  addr: 0};
        spots[5] = '{rd: 4,  k: 15,   poly: 0, bank: 15, addr: 0};
        spots[6] = '{rd: 4,  k: 16,   poly: 1, bank: 0,  addr: 0};
        spots[7] = '{rd: 4,  k: 31,   poly: 1, bank: 15, addr: 0};

        reset      = 1'b1;
        OP_CODE    = 5'b00000;
        din_valid  = 1'b0;
        din0       = 32'd0;
        ring_depth = 4'd10;
        tick();
        tick();
        check_all_zero("reset_state");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_cmd(cmds[i]);
            if (cmds[i].op == 5'b00011 && cmds[i].nw > 0) begin
                for (int s = 0; s < 8; s++) begin
                    if (spots[s].rd == int'(cmds[i].rd)) begin
                        check("spot_poly", cap_poly[spots[s].k], spots[s].poly);
                        check("spot_bank", cap_bank[spots[s].k], spots[s].bank);
                        check("spot_addr", cap_addr[spots[s].k], spots[s].addr);
                    end
                end
            end
        end

        // LOAD_PARAM with a gap after the first word and junk valid in the accept cycle
        OP_CODE   = 5'b00001;
        din_valid = 1'b1;
        din0      = 32'hDEAD_BEEF;
        tick();
        OP_CODE = 5'b00000;
        check("prm_busy", busy, 1);
        din0 = 32'd1;
        push_word(0, 0, 0, 32'd1, 1'b0);
        tick();
        din_valid = 1'b0;
        tick();
        din_valid = 1'b1;
        din0      = 32'h3001;
        push_word(0, 1, 0, 32'h3001, 1'b0);
        tick();
        din0 = 32'h2FFD;
        push_word(0, 2, 0, 32'h2FFD, 1'b1);
        tick();
        din_valid = 1'b0;
        tick();
        check("prm_drained", sb.size(), 0);
        check("prm_idle", busy, 0);

        // START_NTT during LOAD_W is refused, load completes, then START_NTT goes through
        OP_CODE = 5'b00010;
        tick();
        OP_CODE = 5'b00000;
        feed(1, W_COUNT, 0, -1, 100);
        din_valid = 1'b0;
        tick();
        tick();
        check("w_drained", sb.size(), 0);
        OP_CODE    = 5'b00100;
        ring_depth = 4'd10;
        tick();
        OP_CODE = 5'b00000;
        check("ntt_after_load", start_ntt, 1);
        check("ntt_no_err", err, 0);
        tick();
        check("ntt_one_cycle", start_ntt, 0);

        // Reset at word 500 of LOAD_W, then LOAD_PARAM must restart at prm_sel 0
        OP_CODE = 5'b00010;
        tick();
        OP_CODE = 5'b00000;
        feed(1, W_COUNT, 0, 500, -1);
        reset     = 1'b1;
        din_valid = 1'b1;
        din0      = 32'h5555_AAAA;
        tick();
        check_all_zero("mid_load_reset");
        check("reset_drained", sb.size(), 0);
        reset     = 1'b0;
        din_valid = 1'b1;
        tick();
        check("reset_no_strobe", {61'd0, prm_we, w_we, d_we}, 64'd0);
        check("reset_idle", busy, 0);
        din_valid = 1'b0;
        run_cmd(prm_cmd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_host_ctrl.md
# ntt_host_ctrl

Parametrised host-command front end for the NTT cores. It decodes the 5-bit host `OP_CODE`, sequences the streamed loads of parameters, twiddles and polynomial data, and issues one-cycle start strobes to the compute datapath. Data words are scattered across `2^(PE_DEPTH+1)` PE memory banks for any supported ring depth and polynomial count. It sits between the host stream port (`OP_CODE`/`din_valid`/`din0`) and the NTT core memories, replacing fixed-size, fixed-PE-count load logic.

## Interface
- `DATA_W`, default 32: host word width.
- `PE_DEPTH`, default 3: log2 of the PE count; the bank count is `NB = 2^(PE_DEPTH+1)`.
- `MAX_RING_DEPTH`, default 10: largest supported log2(n).
- `NUM_POLY`, default 2: polynomials per `LOAD_DATA` command (≥1).
- `W_COUNT`, default 2552: twiddle words per `LOAD_W` command.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `OP_CODE` input, 5 bits: command; 0 = none.
- `din_valid` input, 1 bit: qualifies `din0`.
- `din0` input, `DATA_W` bits: stream word.
- `ring_depth` input, 4 bits: log2(n), sampled at command accept.
- `prm_we` output, 1 bit: parameter write strobe.
- `prm_sel` output, 2 bits: parameter index (0 = pset, 1 = q, 2 = n_inv).
- `w_we` output, 1 bit: twiddle write strobe.
- `w_addr` output, `clog2(W_COUNT)` bits: twiddle address.
- `d_we` output, 1 bit: data write strobe.
- `d_bank` output, `PE_DEPTH+1` bits: target bank.
- `d_poly` output, `clog2(NUM_POLY)` bits (min 1): polynomial index.
- `d_addr` output, `MAX_RING_DEPTH-PE_DEPTH-1` bits: address within the bank.
- `wdata` output, `DATA_W` bits: registered copy of `din0`.
- `start_ntt`, `start_intt`, `start_pwm` outputs, 1 bit each: one-cycle start pulses.
- `load_done` output, 1 bit: pulses when a load completes.
- `busy` output, 1 bit: high while not in IDLE.
- `err` output, 1 bit: one-cycle pulse on a rejected command.

## Operation
- Opcodes:
  - `00001` LOAD_PARAM: 3 words.
  - `00010` LOAD_W: `W_COUNT` words.
  - `00011` LOAD_DATA: `NUM_POLY·2^ring_depth` words.
  - `00100` START_NTT.
  - `00111` START_INTT.
  - `01010` START_PWM.
  - Any other non-zero code is unsupported.
- FSM states: IDLE, LD_PRM, LD_W, LD_DATA.
  - A command is accepted only in IDLE.
  - Load opcodes move the FSM to the matching LD_ state and clear the word counter `k`.
  - START_* codes pulse their strobe and stay in IDLE.
- Word counting: in each LD_ state, every cycle with `din_valid=1` consumes one word and increments `k`. Gaps with `din_valid=0` are allowed and hold state.
- Completion: when the last word is consumed, the FSM returns to IDLE.
- `din_valid` in the command-accept cycle is ignored.
- LOAD_DATA mapping, with `N = 2^ring_depth` and word index `k`:
  - `d_poly = k >> ring_depth`
  - `j = k mod N`
  - `d_bank = j[PE_DEPTH:0]`
  - `d_addr = j >> (PE_DEPTH+1)`
- LOAD_PARAM: `prm_sel = k`.
- LOAD_W: `w_addr = k`.
- Rejections (each pulses `err`; state is unchanged):
  - Non-zero `OP_CODE` while `busy`.
  - Unsupported opcode.
  - LOAD_DATA or START_* with `ring_depth` outside `[PE_DEPTH+1, MAX_RING_DEPTH]`.
- `ring_depth` is latched at accept. Changes during a load have no effect.
- `reset` mid-load: FSM returns to IDLE, `k` is cleared, and no further strobes are issued. Partial memory contents are undefined.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Write latency: a word consumed in cycle t gives a write strobe, address and `wdata` in cycle t+1.
- Start latency: a START_* accepted in cycle t gives its pulse in cycle t+1.
- Completion: `load_done` pulses in the same cycle as the final write strobe. `busy` falls in that same cycle.
- Back-to-back command: a new command may be presented in the cycle after `busy` falls.

## Structure
- Shared package `ntt_pkg` holds:
  - opcode localparams (`OP_LD_PRM`, `OP_LD_W`, `OP_LD_DATA`, `OP_NTT`, `OP_INTT`, `OP_PWM`);
  - the FSM state enum;
  - the `clog2`-based width helpers.
- Sub-module `ntt_bank_addr_gen` is combinational: it takes `k` and the latched `ring_depth` and produces `d_poly`, `d_bank` and `d_addr`. It is reused by the readout sequencer.

## Test plan
- **LOAD_PARAM:** `OP_CODE=00001`, then words 1, 0x3001, 0x2FFD with a one-cycle `din_valid` gap after word 1 → three `prm_we` pulses, `prm_sel` 0,1,2, data matches, `load_done` on the third, `busy` low after.
- **LOAD_DATA, defaults:** `ring_depth=10`, 2048 words → word 0 at poly0/bank0/addr0; word 17 at poly0/bank1/addr1; word 1024 at poly1/bank0/addr0; word 2047 at poly1/bank15/addr63.
- **LOAD_DATA, small ring:** `ring_depth=4`, `PE_DEPTH=3` → 32 writes, all `d_addr=0`, `load_done` after word 31; `ring_depth=3` → `err` pulse, `busy` stays 0.
- **Busy rejection and start:** `OP_CODE=00100` during LOAD_W → `err` pulse, load completes with 2552 writes, then `00100` → `start_ntt` one cycle later.
- **Reset and bad opcode:** `reset` at word 500 of LOAD_W → all outputs 0 next cycle, FSM in IDLE, a new LOAD_PARAM restarts at `prm_sel=0`; opcode `11111` → `err` only.
